// File: rtl/hamming_secded_dec.sv
// Pipelined Hamming SECDED decoder: 2^P-1 Hamming positions plus an overall
// parity bit in DU[0]. Two register stages with valid/ready flow control and
// saturating corrected/uncorrectable error counters.
// Optional feature: define HAMMING_ERRLOG_EN to add ERR_LOG_VALID/ERR_LOG_SYN,
// a sticky capture of the first erroneous word's {syndrome, parity check}.
// P is meaningful for 3..6.
module hamming_secded_dec #(
  parameter int P    = 3,
  parameter int CNTW = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [2**P-1:0]       DU,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  output logic [2**P-1:0]       DC,
  output logic [2**P-P-2:0]     DOUT,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic                  NOERROR,
  output logic                  CE,
  output logic                  UE,
  input  logic                  CLR_CNT,
  output logic [CNTW-1:0]       CE_CNT,
  output logic [CNTW-1:0]       UE_CNT
`ifdef HAMMING_ERRLOG_EN
  ,
  output logic                  ERR_LOG_VALID,
  output logic [P:0]            ERR_LOG_SYN
`endif
);

  localparam int N = 2**P - 1;   // highest Hamming position
  localparam int K = N - P;      // data bits

  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};
  localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

  // Syndrome bit j is the XOR of every position whose index has bit j set.
  function automatic logic [P-1:0] f_syndrome(input logic [N:0] cw);
    logic [P-1:0] s;
    s = {P{1'b0}};
    for (int i = 1; i <= N; i++) begin
      for (int j = 0; j < P; j++) begin
        if (i[j]) begin
          s[j] = s[j] ^ cw[i];
        end else begin
          s[j] = s[j];
        end
      end
    end
    return s;
  endfunction

  // Even overall parity across the whole received word passes.
  function automatic logic f_parity_fail(input logic [N:0] cw);
    return ^cw;
  endfunction

  // Data bits live at the non-power-of-two positions, packed LSB-first.
  function automatic logic [K-1:0] f_extract(input logic [N:0] cw);
    logic [K-1:0] d;
    int           k;
    d = {K{1'b0}};
    k = 0;
    for (int i = 1; i <= N; i++) begin
      if ((i & (i - 32'sd1)) != 32'sd0) begin
        d[k] = cw[i];
        k    = k + 1;
      end else begin
        k    = k;
      end
    end
    return d;
  endfunction

  // Stage 1 registers
  logic           r_s1_valid;
  logic [N:0]     r_s1_du;
  logic [P-1:0]   r_s1_syn;
  logic           r_s1_pe;

  // Stage 2 registers (drive the outputs directly)
  logic           r_s2_valid;
  logic [N:0]     r_dc;
  logic [K-1:0]   r_dout;
  logic           r_noerr;
  logic           r_ce;
  logic           r_ue;

  logic [CNTW-1:0] r_ce_cnt;
  logic [CNTW-1:0] r_ue_cnt;

  // Handshake and correction wires
  logic           w_s2_ready;
  logic           w_s1_adv;
  logic           w_in_fire;
  logic           w_out_fire;
  logic           w_syn_nz;
  logic [N:0]     w_flip;
  logic [N:0]     w_dc;
  logic [K-1:0]   w_dout;
  logic           w_noerr;
  logic           w_ce;
  logic           w_ue;

  assign w_out_fire = r_s2_valid & OUT_READY;
  assign w_s2_ready = ~r_s2_valid | OUT_READY;
  assign w_s1_adv   = r_s1_valid & w_s2_ready;
  assign IN_READY   = ~r_s1_valid | w_s2_ready;
  assign w_in_fire  = IN_VALID & IN_READY;
  assign w_syn_nz   = (r_s1_syn != {P{1'b0}});

  // Classify the stage-1 word and build the corrected word and data field.
  always_comb begin
    w_flip  = {(N+1){1'b0}};
    w_noerr = 1'b0;
    w_ce    = 1'b0;
    w_ue    = 1'b0;
    case ({w_syn_nz, r_s1_pe})
      2'b00: begin
        w_noerr = 1'b1;
      end
      2'b11: begin
        w_ce             = 1'b1;
        w_flip[r_s1_syn] = 1'b1;
      end
      2'b01: begin
        w_ce      = 1'b1;
        w_flip[0] = 1'b1;
      end
      2'b10: begin
        w_ue = 1'b1;
      end
      default: begin
        w_ue = 1'b1;
      end
    endcase
    w_dc   = r_s1_du ^ w_flip;
    w_dout = f_extract(w_dc);
  end

  // Stage 1: capture the received word with its syndrome and parity check.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_s1_valid <= 1'b0;
      r_s1_du    <= {(N+1){1'b0}};
      r_s1_syn   <= {P{1'b0}};
      r_s1_pe    <= 1'b0;
    end else if (w_in_fire) begin
      r_s1_valid <= 1'b1;
      r_s1_du    <= DU;
      r_s1_syn   <= f_syndrome(DU);
      r_s1_pe    <= f_parity_fail(DU);
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= r_s1_valid;
    end
  end

  // Stage 2: register the corrected word, data and classification flags.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_s2_valid <= 1'b0;
      r_dc       <= {(N+1){1'b0}};
      r_dout     <= {K{1'b0}};
      r_noerr    <= 1'b0;
      r_ce       <= 1'b0;
      r_ue       <= 1'b0;
    end else if (w_s1_adv) begin
      r_s2_valid <= 1'b1;
      r_dc       <= w_dc;
      r_dout     <= w_dout;
      r_noerr    <= w_noerr;
      r_ce       <= w_ce;
      r_ue       <= w_ue;
    end else if (w_out_fire) begin
      r_s2_valid <= 1'b0;
    end else begin
      r_s2_valid <= r_s2_valid;
    end
  end

  // Saturating error counters; a clear beats a same-cycle increment.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_ce_cnt <= {CNTW{1'b0}};
      r_ue_cnt <= {CNTW{1'b0}};
    end else if (CLR_CNT) begin
      r_ce_cnt <= {CNTW{1'b0}};
      r_ue_cnt <= {CNTW{1'b0}};
    end else begin
      if (w_out_fire && r_ce && (r_ce_cnt != CNT_MAX)) begin
        r_ce_cnt <= r_ce_cnt + CNT_ONE;
      end else begin
        r_ce_cnt <= r_ce_cnt;
      end
      if (w_out_fire && r_ue && (r_ue_cnt != CNT_MAX)) begin
        r_ue_cnt <= r_ue_cnt + CNT_ONE;
      end else begin
        r_ue_cnt <= r_ue_cnt;
      end
    end
  end

`ifdef HAMMING_ERRLOG_EN
  logic [P-1:0] r_s2_syn;
  logic         r_s2_pe;
  logic         r_log_valid;
  logic [P:0]   r_log_syn;

  // Carry the syndrome alongside the stage-2 word for the error log.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_s2_syn <= {P{1'b0}};
      r_s2_pe  <= 1'b0;
    end else if (w_s1_adv) begin
      r_s2_syn <= r_s1_syn;
      r_s2_pe  <= r_s1_pe;
    end else begin
      r_s2_syn <= r_s2_syn;
      r_s2_pe  <= r_s2_pe;
    end
  end

  // Sticky capture of the first delivered error since reset or clear.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_log_valid <= 1'b0;
      r_log_syn   <= {(P+1){1'b0}};
    end else if (CLR_CNT) begin
      r_log_valid <= 1'b0;
      r_log_syn   <= {(P+1){1'b0}};
    end else if (w_out_fire && (r_ce || r_ue) && !r_log_valid) begin
      r_log_valid <= 1'b1;
      r_log_syn   <= {r_s2_syn, r_s2_pe};
    end else begin
      r_log_valid <= r_log_valid;
      r_log_syn   <= r_log_syn;
    end
  end

  assign ERR_LOG_VALID = r_log_valid;
  assign ERR_LOG_SYN   = r_log_syn;
`endif

  assign OUT_VALID = r_s2_valid;
  assign DC        = r_dc;
  assign DOUT      = r_dout;
  assign NOERROR   = r_noerr;
  assign CE        = r_ce;
  assign UE        = r_ue;
  assign CE_CNT    = r_ce_cnt;
  assign UE_CNT    = r_ue_cnt;

endmodule

// File: tb/tb_hamming_secded_dec.sv
// Directed bench for hamming_secded_dec (P=3). A second instance with
// CNTW=2 exercises counter saturation and clear priority.
module tb_hamming_secded_dec;

  logic       clk;
  logic       rst;
  logic [7:0] du;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] dc;
  logic [3:0] dout;
  logic       out_valid;
  logic       out_ready;
  logic       noerr;
  logic       ce;
  logic       ue;
  logic       clr;
  logic [15:0] ce_cnt;
  logic [15:0] ue_cnt;

  logic       [7:0] du2;
  logic       in_valid2;
  logic       in_ready2;
  logic [7:0] dc2;
  logic [3:0] dout2;
  logic       out_valid2;
  logic       out_ready2;
  logic       noerr2;
  logic       ce2;
  logic       ue2;
  logic       clr2;
  logic [1:0] ce_cnt2;
  logic [1:0] ue_cnt2;

`ifdef HAMMING_ERRLOG_EN
  logic       log_v;
  logic [3:0] log_syn;
  logic       log_v2;
  logic [3:0] log_syn2;
`endif

  int n_checks;
  int n_fail;

  // captured results of run_single
  logic [7:0] cap_dc;
  logic [3:0] cap_dout;
  logic       cap_ne, cap_ce, cap_ue, cap_got, cap_rdy, cap_after;
  int         cap_lat;

  hamming_secded_dec #(.P(3), .CNTW(16)) u_dut (
    .CLK(clk), .RESET(rst), .DU(du), .IN_VALID(in_valid), .IN_READY(in_ready),
    .DC(dc), .DOUT(dout), .OUT_VALID(out_valid), .OUT_READY(out_ready),
    .NOERROR(noerr), .CE(ce), .UE(ue), .CLR_CNT(clr),
    .CE_CNT(ce_cnt), .UE_CNT(ue_cnt)
`ifdef HAMMING_ERRLOG_EN
    , .ERR_LOG_VALID(log_v), .ERR_LOG_SYN(log_syn)
`endif
  );

  hamming_secded_dec #(.P(3), .CNTW(2)) u_dut2 (
    .CLK(clk), .RESET(rst), .DU(du2), .IN_VALID(in_valid2), .IN_READY(in_ready2),
    .DC(dc2), .DOUT(dout2), .OUT_VALID(out_valid2), .OUT_READY(out_ready2),
    .NOERROR(noerr2), .CE(ce2), .UE(ue2), .CLR_CNT(clr2),
    .CE_CNT(ce_cnt2), .UE_CNT(ue_cnt2)
`ifdef HAMMING_ERRLOG_EN
    , .ERR_LOG_VALID(log_v2), .ERR_LOG_SYN(log_syn2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Send one word on the main instance with OUT_READY high and capture the result.
  task automatic run_single(input logic [7:0] w);
    @(negedge clk);
    du = w;
    in_valid = 1'b1;
    #1 cap_rdy = in_ready;
    @(posedge clk);
    #1 in_valid = 1'b0;
    cap_lat = 0;
    cap_got = 1'b0;
    while (!cap_got && cap_lat < 10) begin
      @(posedge clk);
      #1 cap_lat++;
      if (out_valid) cap_got = 1'b1;
    end
    cap_dc = dc; cap_dout = dout; cap_ne = noerr; cap_ce = ce; cap_ue = ue;
    @(posedge clk);
    #1 cap_after = out_valid;
  endtask

  task automatic test_reset;
    rst = 1'b1; du = 8'h00; in_valid = 1'b0; out_ready = 1'b1; clr = 1'b0;
    du2 = 8'h00; in_valid2 = 1'b0; out_ready2 = 1'b1; clr2 = 1'b0;
    #12;
    n_checks++; if (out_valid !== 1'b0) begin $display("FAIL reset_out_valid: got %b expected 0", out_valid); n_fail++; end
    n_checks++; if ({dc, dout, noerr, ce, ue} !== 15'h0) begin $display("FAIL reset_outputs: got dc=%h dout=%h ne=%b ce=%b ue=%b expected all 0", dc, dout, noerr, ce, ue); n_fail++; end
    n_checks++; if ({ce_cnt, ue_cnt} !== 32'h0) begin $display("FAIL reset_counters: got ce=%0d ue=%0d expected 0", ce_cnt, ue_cnt); n_fail++; end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin $display("FAIL reset_in_ready: got %b expected 1", in_ready); n_fail++; end
  endtask

  task automatic test_noerror;
    run_single(8'h00);
    n_checks++; if (!cap_got || cap_lat + 1 != 2) begin $display("FAIL noerr_latency: got %0d edges (seen=%b) expected 2", cap_lat + 1, cap_got); n_fail++; end
    n_checks++; if ({cap_ne, cap_ce, cap_ue} !== 3'b100) begin $display("FAIL noerr_flags: got ne/ce/ue=%b expected 100", {cap_ne, cap_ce, cap_ue}); n_fail++; end
    n_checks++; if (cap_dc !== 8'h00 || cap_dout !== 4'h0) begin $display("FAIL noerr_data: got dc=%h dout=%h expected 00/0", cap_dc, cap_dout); n_fail++; end
    n_checks++; if (cap_after !== 1'b0) begin $display("FAIL noerr_single_delivery: got out_valid=%b expected 0", cap_after); n_fail++; end
    n_checks++; if ({ce_cnt, ue_cnt} !== 32'h0) begin $display("FAIL noerr_counters: got ce=%0d ue=%0d expected 0", ce_cnt, ue_cnt); n_fail++; end
    // clean codeword for data 1011
    run_single(8'hAA);
    n_checks++; if (!cap_ne || cap_dc !== 8'hAA || cap_dout !== 4'hB) begin $display("FAIL clean_word: got ne=%b dc=%h dout=%h expected 1/aa/b", cap_ne, cap_dc, cap_dout); n_fail++; end
  endtask

  task automatic test_double;
    run_single(8'hEE);   // 0xAA with positions 2 and 6 flipped
    n_checks++; if ({cap_ne, cap_ce, cap_ue} !== 3'b001) begin $display("FAIL double_flags: got ne/ce/ue=%b expected 001", {cap_ne, cap_ce, cap_ue}); n_fail++; end
    n_checks++; if (cap_dc !== 8'hEE || cap_dout !== 4'hF) begin $display("FAIL double_data: got dc=%h dout=%h expected ee/f", cap_dc, cap_dout); n_fail++; end
    n_checks++; if (ue_cnt !== 16'd1 || ce_cnt !== 16'd0) begin $display("FAIL double_counters: got ce=%0d ue=%0d expected 0/1", ce_cnt, ue_cnt); n_fail++; end
`ifdef HAMMING_ERRLOG_EN
    n_checks++; if (log_v !== 1'b1 || log_syn !== 4'b1000) begin $display("FAIL double_errlog: got v=%b syn=%b expected 1/1000", log_v, log_syn); n_fail++; end
`endif
  endtask

  task automatic test_single;
    logic [7:0] wv [0:2];
    wv[0] = 8'h8A;  // position 5 flipped
    wv[1] = 8'hA2;  // position 3 flipped
    wv[2] = 8'hAB;  // overall parity bit flipped
    for (int i = 0; i < 3; i++) begin
      run_single(wv[i]);
      n_checks++; if ({cap_ne, cap_ce, cap_ue} !== 3'b010) begin $display("FAIL single_flags[%0d]: got ne/ce/ue=%b expected 010", i, {cap_ne, cap_ce, cap_ue}); n_fail++; end
      n_checks++; if (cap_dc !== 8'hAA || cap_dout !== 4'hB) begin $display("FAIL single_data[%0d]: got dc=%h dout=%h expected aa/b", i, cap_dc, cap_dout); n_fail++; end
      n_checks++; if (ce_cnt !== 16'(i + 1)) begin $display("FAIL single_ce_cnt[%0d]: got %0d expected %0d", i, ce_cnt, i + 1); n_fail++; end
    end
`ifdef HAMMING_ERRLOG_EN
    n_checks++; if (log_v !== 1'b1 || log_syn !== 4'b1000) begin $display("FAIL errlog_sticky: got v=%b syn=%b expected 1/1000", log_v, log_syn); n_fail++; end
`endif
  endtask

  task automatic test_back_to_back;
    logic [7:0] wv [0:3];
    logic [7:0] edc [0:3];
    logic [3:0] edo [0:3];
    int sent, recv;
    logic saw_block, stalled_prev, fire;
    logic [7:0] held_dc;
    logic [3:0] held_dout;
    wv[0] = 8'h0F; edc[0] = 8'h0F; edo[0] = 4'h1;
    wv[1] = 8'h31; edc[1] = 8'h33; edo[1] = 4'h2;   // position 1 flipped
    wv[2] = 8'h55; edc[2] = 8'h55; edo[2] = 4'h4;
    wv[3] = 8'h96; edc[3] = 8'h96; edo[3] = 4'h8;
    sent = 0; recv = 0; saw_block = 1'b0; stalled_prev = 1'b0;
    held_dc = 8'h00; held_dout = 4'h0;
    for (int cyc = 0; cyc < 40 && recv < 4; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 2 && cyc <= 4);
      if (sent < 4) begin in_valid = 1'b1; du = wv[sent]; end
      else in_valid = 1'b0;
      #1;
      if (sent < 4 && !in_ready) saw_block = 1'b1;
      if (stalled_prev) begin
        n_checks++; if (out_valid !== 1'b1 || dc !== held_dc || dout !== held_dout) begin $display("FAIL stall_hold: got v=%b dc=%h dout=%h expected 1/%h/%h", out_valid, dc, dout, held_dc, held_dout); n_fail++; end
      end
      if (out_valid && out_ready) begin
        n_checks++; if (dc !== edc[recv] || dout !== edo[recv]) begin $display("FAIL burst_order[%0d]: got dc=%h dout=%h expected %h/%h", recv, dc, dout, edc[recv], edo[recv]); n_fail++; end
        recv++;
      end
      stalled_prev = out_valid && !out_ready;
      held_dc = dc;
      held_dout = dout;
      fire = in_valid && in_ready;
      @(posedge clk);
      if (fire) sent++;
    end
    #1 in_valid = 1'b0;
    out_ready = 1'b1;
    n_checks++; if (recv != 4 || sent != 4) begin $display("FAIL burst_count: got sent=%0d recv=%0d expected 4/4", sent, recv); n_fail++; end
    n_checks++; if (saw_block !== 1'b1) begin $display("FAIL burst_backpressure: got in_ready_dropped=%b expected 1", saw_block); n_fail++; end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (out_valid !== 1'b0) begin $display("FAIL burst_no_dup[%0d]: got out_valid=%b expected 0", i, out_valid); n_fail++; end
    end
    n_checks++; if (ce_cnt !== 16'd4) begin $display("FAIL burst_ce_cnt: got %0d expected 4", ce_cnt); n_fail++; end
  endtask

  task automatic test_saturate;
    int acc;
    @(negedge clk);
    du2 = 8'h8A;
    in_valid2 = 1'b1;
    acc = 0;
    for (int i = 0; i < 20 && acc < 5; i++) begin
      #1 if (in_ready2) acc++;
      @(negedge clk);
    end
    in_valid2 = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++; if (ce_cnt2 !== 2'd3 || acc != 5) begin $display("FAIL sat_ce_cnt: got %0d (accepted %0d) expected 3", ce_cnt2, acc); n_fail++; end
    // clear together with a CE transfer
    in_valid2 = 1'b1;
    @(negedge clk);
    in_valid2 = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid2 !== 1'b1 || ce2 !== 1'b1) begin $display("FAIL clr_setup: got v=%b ce=%b expected 1/1", out_valid2, ce2); n_fail++; end
    clr2 = 1'b1;
    @(negedge clk);
    clr2 = 1'b0;
    n_checks++; if (ce_cnt2 !== 2'd0 || out_valid2 !== 1'b0) begin $display("FAIL clr_wins: got cnt=%0d v=%b expected 0/0", ce_cnt2, out_valid2); n_fail++; end
`ifdef HAMMING_ERRLOG_EN
    n_checks++; if (log_v2 !== 1'b0 || log_syn2 !== 4'b0000) begin $display("FAIL clr_errlog: got v=%b syn=%b expected 0/0000", log_v2, log_syn2); n_fail++; end
`endif
  endtask

  task automatic test_reset_midflight;
    logic seen;
    @(negedge clk);
    du = 8'h0F;
    in_valid = 1'b1;
    @(negedge clk);          // word accepted into stage 1
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0 || dc !== 8'h00 || ce_cnt !== 16'd0) begin $display("FAIL midreset_clear: got v=%b dc=%h ce_cnt=%0d expected 0/00/0", out_valid, dc, ce_cnt); n_fail++; end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) begin $display("FAIL midreset_discard: got delivered=%b expected 0", seen); n_fail++; end
    n_checks++; if (in_ready !== 1'b1) begin $display("FAIL midreset_in_ready: got %b expected 1", in_ready); n_fail++; end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_noerror();
    test_double();
    test_single();
    test_back_to_back();
    test_saturate();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
